// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types for the seven-segment scan driver
package seg_scan_pkg;
    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } scan_state_t;
endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - loadable down counter with terminal-count flag
module seg_scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver with frame-boundary updates
module seg_scan_driver #(
    parameter int D          = 2,
    parameter int DIV        = 50000,
    parameter int GAP        = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [D-1:0][6:0]   s_data,
    output logic [6:0]          m_seg,
    output logic [D-1:0]        m_an
);
    import seg_scan_pkg::*;

    localparam int MAXC  = (DIV > GAP) ? DIV : GAP;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IDX_W = $clog2(D);

    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D - 1);
    localparam logic [D-1:0]     AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam seg_t             SEG_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    seg_t [D-1:0]        frame_q, frame_d;
    logic [D-1:0]        m_an_q, m_an_d;
    seg_t                m_seg_q, m_seg_d;
    logic [D-1:0]        an_raw;
    seg_t                seg_raw;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_tc;

    seg_scan_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // The wrap cycle (last gap cycle after the final digit) doubles as the accept window.
    assign s_ready = !rst && ((state_q == seg_scan_pkg::IDLE) ||
                     ((state_q == seg_scan_pkg::GAP) && (idx_q == IDX_LAST) && tmr_tc));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        tmr_load = 1'b0;
        tmr_val  = DIV_LD;
        case (state_q)
            seg_scan_pkg::IDLE: begin
                if (s_valid) begin
                    state_d  = seg_scan_pkg::ON;
                    idx_d    = '0;
                    frame_d  = s_data;
                    tmr_load = 1'b1;
                end
            end
            seg_scan_pkg::ON: begin
                if (tmr_tc) begin
                    state_d  = seg_scan_pkg::GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            seg_scan_pkg::GAP: begin
                if (tmr_tc) begin
                    state_d  = seg_scan_pkg::ON;
                    tmr_load = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (s_valid) begin
                            frame_d = s_data;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = seg_scan_pkg::IDLE;
        endcase
    end

    // Outputs are decoded from next state so they line up with the state register.
    always_comb begin
        an_raw  = '0;
        seg_raw = '0;
        if (state_d == seg_scan_pkg::ON) begin
            an_raw[idx_d] = 1'b1;
            seg_raw       = frame_d[idx_d];
        end
        m_an_d  = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
        m_seg_d = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seg_scan_pkg::IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            m_an_q  <= AN_OFF;
            m_seg_q <= SEG_OFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            m_an_q  <= m_an_d;
            m_seg_q <= m_seg_d;
        end
    end

    assign m_an  = m_an_q;
    assign m_seg = m_seg_q;
endmodule
